seq_mult_sched: RTL and testbench
=================================

SEQ_MULT_SCHED -- requirements
Module: seq_mult_sched

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (power of two, at least 2).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk SHALL be an input, 1 bit: the single rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-006 Port req SHALL be an input, NREQ bits: per-requester multiply request, level-held.
REQ-007 Port opa_bus SHALL be an input, NREQ*SIZE bits: multiplicand of requester i in slice [i*SIZE +: SIZE].
REQ-008 Port opb_bus SHALL be an input, NREQ*SIZE bits: multiplier of requester i in slice [i*SIZE +: SIZE].
REQ-009 Port gnt SHALL be an output, NREQ bits: one-hot, one-cycle pulse that acknowledges operand capture.
REQ-010 Port busy SHALL be an output, 1 bit: high while the state is CALC or DONE.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle pulse that marks result valid.
REQ-012 Port done_id SHALL be an output, log2(NREQ) bits: index of the requester whose product is on result.
REQ-013 Port result SHALL be an output, 2*SIZE bits: unsigned product.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 In IDLE with any req bit high, at clock edge E0 the FSM SHALL:
- pick one requester round-robin, starting at the index after the last-granted requester;
- capture that requester's opa/opb slices, zero-extended to 2*SIZE bits;
- clear the accumulator and the iteration counter;
- move to CALC.
REQ-016 gnt SHALL be high for exactly the one cycle that follows E0, on the selected bit only.
REQ-017 Each CALC edge SHALL:
- add the shifted multiplicand to the accumulator if multiplier bit 0 is 1;
- shift the multiplicand left 1;
- shift the multiplier right 1;
- increment the counter.
REQ-018 Accumulator arithmetic SHALL be 2*SIZE bits wide and SHALL never overflow.
REQ-019 After SIZE CALC edges, the FSM SHALL load result and done_id and move to DONE; done SHALL then be visible at edge E0+SIZE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; the earliest next capture is edge E0+SIZE+2.
REQ-021 result and done_id SHALL hold their values until the next done.
REQ-022 req changes while busy SHALL be ignored; pending requesters SHALL wait without being dropped.
REQ-023 A requester that drops req before its gnt SHALL NOT be served.
REQ-024 Operands SHALL be sampled only at E0; later changes to opa_bus/opb_bus SHALL have no effect on the running operation.
REQ-025 With all requests held continuously, each requester SHALL be granted once every NREQ operations.

Reset
REQ-026 Reset SHALL force:
- state IDLE;
- gnt=0, busy=0, done=0, done_id=0, result=0;
- round-robin pointer such that requester 0 has top priority.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-028 With EARLY_TERM_EN defined, CALC SHALL exit to DONE at the first edge after which the shifted multiplier is zero: CALC length = max(1, position of highest set bit of opb + 1).
REQ-029 Without EARLY_TERM_EN, CALC SHALL always last SIZE edges.
REQ-030 result values SHALL be identical in both builds.

Structure
REQ-031 Package seq_mult_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default SIZE/NREQ constants.
REQ-032 Sub-module shift_add_dp SHALL contain the accumulator, the shift registers and the counter.
REQ-033 seq_mult_sched SHALL hold the FSM, the arbiter and the output registers.

Verification
REQ-034 req=0001, opa0=13, opb0=11 -> gnt=0001 one cycle; result=143, done_id=0; done 8 edges after capture (no macro).
REQ-035 opa=255, opb=255 -> result=65025; opa=0 or opb=0 -> result=0.
REQ-036 All req=1111 from reset, held -> gnt order 0,1,2,3,0; distinct products correct per done_id.
REQ-037 rst_n low 3 cycles mid-CALC -> no done; all outputs 0; next req=0100 served correctly.
REQ-038 EARLY_TERM_EN, opb=1 -> done 1 edge after capture; opb=0x80 -> 8 edges; results match the non-macro build.
REQ-039 req1 changes opa1 after gnt -> result uses the captured value; req2 raised while busy -> served next, not lost.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state type and default sizes for the scheduled multiplier
package seq_mult_pkg;
  localparam int SIZE_DEF = 8;
  localparam int NREQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/shift_add_dp.sv
// shift_add_dp: shift-add multiply datapath (accumulator, operand shifters, step counter; EARLY_TERM_EN ends when multiplier empties)
module shift_add_dp #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [SIZE-1:0]   a_in,
  input  logic [SIZE-1:0]   b_in,
  output logic [2*SIZE-1:0] acc_nxt,
  output logic              last
);
  localparam int CW = $clog2(SIZE + 1);
  logic [2*SIZE-1:0] mcand, acc;
  logic [SIZE-1:0]   mplier;
  logic [CW-1:0]     cnt;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`ifdef EARLY_TERM_EN
  assign last = cnt == CW'(SIZE - 1) || mplier[SIZE-1:1] == '0;
`else
  assign last = cnt == CW'(SIZE - 1);
`endif
  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= {{SIZE{1'b0}}, a_in};
      mplier <= b_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/seq_mult_sched.sv
// seq_mult_sched: round-robin scheduled sequential multiplier (FSM, arbiter, outputs; EARLY_TERM_EN selects early CALC exit)
module seq_mult_sched
  import seq_mult_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SIZE-1:0]     opa_bus,
  input  logic [NREQ*SIZE-1:0]     opb_bus,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [2*SIZE-1:0]        result
);
  localparam int LW = $clog2(NREQ);
  state_t            state;
  logic [LW-1:0]     ptr, sel;
  logic              start, last;
  logic [2*SIZE-1:0] acc_nxt;
  assign start = state == IDLE && |req;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  always_comb begin
    sel = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[ptr + LW'(k)]) sel = ptr + LW'(k);
  end
  shift_add_dp #(.SIZE(SIZE)) u_dp (
    .clk     (clk),
    .load    (start),
    .step    (state == CALC),
    .a_in    (opa_bus[sel*SIZE +: SIZE]),
    .b_in    (opb_bus[sel*SIZE +: SIZE]),
    .acc_nxt (acc_nxt),
    .last    (last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '1;
      gnt     <= '0;
      done_id <= '0;
      result  <= '0;
    end else begin
      gnt <= start ? (NREQ'(1) << sel) : '0;
      if (start) begin
        state <= CALC;
        ptr   <= sel;
      end else if (state == CALC && last) begin
        state   <= DONE;
        result  <= acc_nxt;
        done_id <= ptr;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_sched.sv
// tb_seq_mult_sched: table-driven and scoreboarded check of seq_mult_sched
module tb_seq_mult_sched;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  req = '0;
  logic [7:0]  a[4], b[4];
  logic [31:0] opa_bus, opb_bus;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic [15:0] result;
  assign opa_bus = {a[3], a[2], a[1], a[0]};
  assign opb_bus = {b[3], b[2], b[1], b[0]};
  seq_mult_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .opa_bus (opa_bus),
    .opb_bus (opb_bus),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result)
  );
  always #5 clk = ~clk;
  typedef struct {int id; logic [15:0] prod; int due;} exp_t;
  typedef struct {int id; logic [7:0] a; logic [7:0] b; logic [15:0] prod;} vec_t;
  exp_t sb[$];
  int   gnt_ids[$];
  int   checks = 0, failures = 0, cyc = 0, exp_ptr = 3;
  function automatic int lat(logic [7:0] bb);
    int h = 1;
    int early = 0;
`ifdef EARLY_TERM_EN
    early = 1;
`endif
    for (int i = 0; i < 8; i++) if (bb[i]) h = i + 1;
    return early != 0 ? h : SIZE;
  endfunction
  function automatic int rr_pick(logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(exp_ptr + k) % 4]) return (exp_ptr + k) % 4;
    return -1;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin : mon
    int id;
    exp_t e;
    #1;
    cyc++;
    if (!rst_n) begin
      exp_ptr = 3;
      sb.delete();
    end else begin
      if (gnt != 0) begin
        id = rr_pick(req);
        if (id < 0) chk("gnt_unrequested", 32'(gnt), 0);
        else begin
          chk("gnt_onehot", 32'(gnt), 32'(4'b1 << id));
          sb.push_back('{id, 16'(a[id]) * 16'(b[id]), cyc + lat(b[id])});
          exp_ptr = id;
          gnt_ids.push_back(id);
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          e = sb.pop_front();
          chk("sb_result", 32'(result), 32'(e.prod));
          chk("sb_done_id", 32'(done_id), e.id);
          chk("sb_latency", cyc, e.due);
        end
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_gnt();
    for (int i = 0; i < 40 && gnt == 0; i++) @(negedge clk);
    chk("gnt_seen", 32'(gnt != 0), 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 80 && (busy || sb.size() != 0); i++) @(negedge clk);
    chk("idle_seen", 32'(busy), 0);
  endtask
  task automatic chk_zero(string name);
    chk({name, "_gnt"}, 32'(gnt), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_done_id"}, 32'(done_id), 0);
    chk({name, "_result"}, 32'(result), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[9];
    int g1;
    tv = '{'{0, 8'd13, 8'd11, 16'd143}, '{1, 8'd255, 8'd255, 16'd65025},
           '{2, 8'd0, 8'd200, 16'd0}, '{3, 8'd77, 8'd0, 16'd0},
           '{0, 8'd1, 8'd1, 16'd1}, '{1, 8'd128, 8'd2, 16'd256},
           '{2, 8'd200, 8'd3, 16'd600}, '{3, 8'd128, 8'd128, 16'd16384},
           '{0, 8'd37, 8'd129, 16'd4773}};
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    tick(3);
    chk_zero("reset");
    rst_n = 1;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      a[tv[i].id] = tv[i].a;
      b[tv[i].id] = tv[i].b;
      req[tv[i].id] = 1'b1;
      wait_gnt();
      chk("tbl_gnt", 32'(gnt), 32'(4'b1 << tv[i].id));
      req[tv[i].id] = 1'b0;
      a[tv[i].id] = ~tv[i].a;
      b[tv[i].id] = 8'($urandom);
      tick(1);
      chk("tbl_gnt_pulse", 32'(gnt), 0);
      wait_done();
      chk("tbl_result", 32'(result), 32'(tv[i].prod));
      chk("tbl_done_id", 32'(done_id), tv[i].id);
      tick(1);
    end
    rst_n = 0;
    tick(2);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      a[i] = 8'(3 + 2 * i);
      b[i] = 8'(10 * (i + 1));
    end
    gnt_ids.delete();
    req = 4'hF;
    for (int i = 0; i < 200 && gnt_ids.size() < 5; i++) @(negedge clk);
    req = '0;
    chk("rr_count", gnt_ids.size(), 5);
    for (int i = 0; i < 5 && i < gnt_ids.size(); i++) chk("rr_order", gnt_ids[i], i % 4);
    wait_idle();
    a[0] = 8'd50;
    b[0] = 8'd60;
    req = 4'b0001;
    wait_gnt();
    req = '0;
    tick(3);
    rst_n = 0;
    tick(3);
    chk_zero("midcalc_reset");
    rst_n = 1;
    a[2] = 8'd21;
    b[2] = 8'd19;
    req = 4'b0100;
    wait_gnt();
    chk("post_reset_gnt", 32'(gnt), 32'(4'b0100));
    req = '0;
    wait_done();
    chk("post_reset_result", 32'(result), 399);
    chk("post_reset_done_id", 32'(done_id), 2);
    tick(1);
    a[1] = 8'd100;
    b[1] = 8'd3;
    req = 4'b0010;
    wait_gnt();
    g1 = cyc;
    req[1] = 1'b0;
    a[1] = 8'd7;
    b[1] = 8'd255;
    tick(1);
    a[2] = 8'd9;
    b[2] = 8'd9;
    a[3] = 8'd5;
    b[3] = 8'd5;
    req[2] = 1'b1;
    req[3] = 1'b1;
    tick(1);
    req[3] = 1'b0;
    wait_done();
    chk("captured_result", 32'(result), 300);
    wait_gnt();
    chk("pending_gnt", 32'(gnt), 32'(4'b0100));
    chk("pending_gap", cyc - g1, lat(8'd3) + 2);
    req[2] = 1'b0;
    wait_done();
    chk("pending_result", 32'(result), 81);
    chk("pending_done_id", 32'(done_id), 2);
    tick(15);
    chk("final_busy", 32'(busy), 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
